cdc_tx_arbiter: RTL and testbench

//  Slow-domain (clk1-side) scheduler for the delay-count slow->fast sampler.

---
 rtl/cdc_tx_arbiter_if.sv | 26 ++
 rtl/cdc_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_cdc_tx_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_tx_arbiter_if.sv
// Requester/sampler-side bundle for cdc_tx_arbiter.
// The master modport is the requester/sampler side; the slave modport is the arbiter.
interface cdc_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned IDW     = 2
);
  logic                   enable;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DW-1:0]          din;
  logic                   din_en;
  logic [IDW-1:0]         din_id;
  logic                   busy;

  modport master (
    output enable, req_valid, req_data,
    input  req_ready, din, din_en, din_id, busy
  );

  modport slave (
    input  enable, req_valid, req_data,
    output req_ready, din, din_en, din_id, busy
  );
endinterface

// File: rtl/cdc_tx_arbiter.sv
// Slow-domain round-robin scheduler feeding one din/din_en sampler path.
// Each granted word is held with din_en high, then followed by a forced low gap.
module cdc_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned IDW      = 2,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  cdc_tx_arbiter_if.slave   bus
);

  localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned GCW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]      din_q, din_d;
  logic [IDW-1:0]     din_id_q, din_id_d;
  logic               din_en_q, din_en_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               found_c;
  logic               grant_c;
  logic [IDW-1:0]     winner_c;
  logic [DW-1:0]      req_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = bus.req_data[g*DW +: DW];
  end

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found_c && bus.req_valid[IDW'((32'(ptr_q) + k) % NUM_REQ)]) begin
        found_c  = 1'b1;
        winner_c = IDW'((32'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Reset is included so no accept pulse escapes while the block is held in reset.
  assign grant_c = (state_q == S_IDLE) && bus.enable && found_c && rstn;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    din_d       = din_q;
    din_id_d    = din_id_q;
    din_en_d    = din_en_q;
    busy_d      = busy_q;
    req_ready_c = '0;

    case (state_q)
      S_IDLE: begin
        din_en_d = 1'b0;
        busy_d   = 1'b0;
        if (grant_c) begin
          req_ready_c = NUM_REQ'(1) << winner_c;
          din_d       = req_word[winner_c];
          din_id_d    = winner_c;
          din_en_d    = 1'b1;
          busy_d      = 1'b1;
          hold_cnt_d  = HCW'(HOLD_CYC - 1);
          ptr_d       = (winner_c == IDW'(NUM_REQ - 1)) ? '0 : winner_c + IDW'(1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        busy_d = 1'b1;
        if (hold_cnt_q == '0) begin
          din_en_d  = 1'b0;
          gap_cnt_d = GCW'(GAP_CYC - 1);
          state_d   = S_GAP;
        end else begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end
      end
      S_GAP: begin
        din_en_d = 1'b0;
        busy_d   = 1'b1;
        if (gap_cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GCW'(1);
        end
      end
      default: begin
        din_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      din_q      <= '0;
      din_id_q   <= '0;
      din_en_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      din_q      <= din_d;
      din_id_q   <= din_id_d;
      din_en_q   <= din_en_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.din       = din_q;
  assign bus.din_en    = din_en_q;
  assign bus.din_id    = din_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: default build plus a HOLD_CYC=1 build.
module tb_cdc_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned IDW     = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cdc_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) bus  ();
  cdc_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW)) bus6 ();

  cdc_tx_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW), .HOLD_CYC(2), .GAP_CYC(1)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  cdc_tx_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .IDW(IDW), .HOLD_CYC(1), .GAP_CYC(1)) u_dut6 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus6.slave)
  );

  function automatic logic [DW-1:0] word_of(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Land 1 time unit after the falling edge; drives go here, checks follow a further #1.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.enable    = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = {word_of(3), word_of(2), word_of(1), word_of(0)};
    bus6.enable    = 1'b0;
    bus6.req_valid = '0;
    bus6.req_data  = '0;
    #2;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b exp 0000", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.din_en !== 1'b0) begin n_fail++; $display("FAIL reset_din_en: got %b exp 0", bus.din_en); end
    n_checks++; if (bus.din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h exp 0", bus.din); end
    n_checks++; if (bus.din_id !== 2'd0) begin n_fail++; $display("FAIL reset_din_id: got %0d exp 0", bus.din_id); end
    next_cycle();
    next_cycle();
    bus.req_valid = '0;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_single();
    next_cycle();
    bus.enable    = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data  = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b exp 0100", bus.req_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b exp 0", bus.busy); end
    next_cycle();
    bus.req_valid = '0;
    bus.req_data  = '0;
    #1;
    n_checks++; if (bus.din !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_din: got %h exp a5a50002", bus.din); end
    n_checks++; if (bus.din_id !== 2'd2) begin n_fail++; $display("FAIL single_din_id: got %0d exp 2", bus.din_id); end
    n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL single_en_h1: got %b exp 1", bus.din_en); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_h1: got %b exp 1", bus.busy); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_hold: got %b exp 0000", bus.req_ready); end
    next_cycle(); #1;
    n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL single_en_h2: got %b exp 1", bus.din_en); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_h2: got %b exp 1", bus.busy); end
    next_cycle(); #1;
    n_checks++; if (bus.din_en !== 1'b0) begin n_fail++; $display("FAIL single_en_gap: got %b exp 0", bus.din_en); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap: got %b exp 1", bus.busy); end
    n_checks++; if (bus.din !== 32'hA5A5_0002) begin n_fail++; $display("FAIL single_din_gap: got %h exp a5a50002", bus.din); end
    next_cycle(); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b exp 0", bus.busy); end
    n_checks++; if (bus.din_id !== 2'd2) begin n_fail++; $display("FAIL single_id_hold: got %0d exp 2", bus.din_id); end
  endtask

  task automatic pulse_reset();
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_round_robin();
    next_cycle();
    bus.enable    = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = {word_of(3), word_of(2), word_of(1), word_of(0)};
    #1;
    for (int w = 0; w < 8; w++) begin
      if (w > 0) begin next_cycle(); #1; end
      n_checks++; if (bus.req_ready !== 4'(1 << (w % 4))) begin n_fail++; $display("FAIL rr_ready w%0d: got %b exp %b", w, bus.req_ready, 4'(1 << (w % 4))); end
      n_checks++; if (bus.din_en !== 1'b0) begin n_fail++; $display("FAIL rr_en_grant w%0d: got %b exp 0", w, bus.din_en); end
      next_cycle(); #1;
      n_checks++; if (bus.din !== word_of(w % 4)) begin n_fail++; $display("FAIL rr_din w%0d: got %h exp %h", w, bus.din, word_of(w % 4)); end
      n_checks++; if (bus.din_id !== 2'(w % 4)) begin n_fail++; $display("FAIL rr_id w%0d: got %0d exp %0d", w, bus.din_id, w % 4); end
      n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL rr_en_h1 w%0d: got %b exp 1", w, bus.din_en); end
      next_cycle(); #1;
      n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL rr_en_h2 w%0d: got %b exp 1", w, bus.din_en); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ready_hold w%0d: got %b exp 0000", w, bus.req_ready); end
      next_cycle(); #1;
      n_checks++; if (bus.din_en !== 1'b0) begin n_fail++; $display("FAIL rr_en_gap w%0d: got %b exp 0", w, bus.din_en); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_ready_gap w%0d: got %b exp 0000", w, bus.req_ready); end
    end
  endtask

  task automatic test_wrap();
    next_cycle();
    bus.req_valid = 4'b1001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b exp 0001", bus.req_ready); end
    next_cycle(); #1;
    n_checks++; if (bus.din_id !== 2'd0) begin n_fail++; $display("FAIL wrap_id0: got %0d exp 0", bus.din_id); end
    next_cycle();
    next_cycle();
    next_cycle(); #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3: got %b exp 1000", bus.req_ready); end
    next_cycle();
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.din_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3: got %0d exp 3", bus.din_id); end
    n_checks++; if (bus.din !== word_of(3)) begin n_fail++; $display("FAIL wrap_din3: got %h exp %h", bus.din, word_of(3)); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_enable();
    next_cycle();
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL en_ready1: got %b exp 0010", bus.req_ready); end
    next_cycle();
    bus.enable    = 1'b0;
    bus.req_valid = '1;
    #1;
    n_checks++; if (bus.din_id !== 2'd1) begin n_fail++; $display("FAIL en_id1: got %0d exp 1", bus.din_id); end
    n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL en_h1: got %b exp 1", bus.din_en); end
    next_cycle(); #1;
    n_checks++; if (bus.din_en !== 1'b1) begin n_fail++; $display("FAIL en_h2: got %b exp 1", bus.din_en); end
    next_cycle(); #1;
    n_checks++; if (bus.din_en !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL en_gap: got en=%b busy=%b exp en=0 busy=1", bus.din_en, bus.busy); end
    for (int c = 0; c < 3; c++) begin
      next_cycle(); #1;
      n_checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL en_off c%0d: got ready=%b busy=%b exp 0000/0", c, bus.req_ready, bus.busy); end
    end
    next_cycle();
    bus.enable = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL en_resume_ready: got %b exp 0100", bus.req_ready); end
    next_cycle(); #1;
    n_checks++; if (bus.din_en !== 1'b1 || bus.din_id !== 2'd2) begin n_fail++; $display("FAIL en_resume_din: got en=%b id=%0d exp en=1 id=2", bus.din_en, bus.din_id); end
  endtask

  // Entered while u_dut is in its first HOLD cycle for ch2.
  task automatic test_reset_mid_hold();
    rstn = 1'b0;
    #1;
    n_checks++; if (bus.din_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %b exp 0", bus.din_en); end
    n_checks++; if (bus.din !== 32'h0) begin n_fail++; $display("FAIL mid_rst_din: got %h exp 0", bus.din); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b exp 0", bus.busy); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 0000", bus.req_ready); end
    next_cycle();
    rstn = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_rst_regrant: got %b exp 0001", bus.req_ready); end
    next_cycle(); #1;
    n_checks++; if (bus.din_id !== 2'd0 || bus.din !== word_of(0)) begin n_fail++; $display("FAIL mid_rst_din0: got id=%0d din=%h exp id=0 din=%h", bus.din_id, bus.din, word_of(0)); end
    bus.enable    = 1'b0;
    bus.req_valid = '0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_short_hold();
    next_cycle();
    bus6.enable    = 1'b1;
    bus6.req_valid = '1;
    bus6.req_data  = {word_of(3), word_of(2), word_of(1), word_of(0)};
    #1;
    for (int w = 0; w < 4; w++) begin
      if (w > 0) begin next_cycle(); #1; end
      n_checks++; if (bus6.req_ready !== 4'(1 << w)) begin n_fail++; $display("FAIL short_ready w%0d: got %b exp %b", w, bus6.req_ready, 4'(1 << w)); end
      n_checks++; if (bus6.din_en !== 1'b0) begin n_fail++; $display("FAIL short_en_grant w%0d: got %b exp 0", w, bus6.din_en); end
      next_cycle(); #1;
      n_checks++; if (bus6.din_en !== 1'b1 || bus6.din_id !== 2'(w)) begin n_fail++; $display("FAIL short_hold w%0d: got en=%b id=%0d exp en=1 id=%0d", w, bus6.din_en, bus6.din_id, w); end
      n_checks++; if (bus6.din !== word_of(w)) begin n_fail++; $display("FAIL short_din w%0d: got %h exp %h", w, bus6.din, word_of(w)); end
      next_cycle(); #1;
      n_checks++; if (bus6.din_en !== 1'b0 || bus6.busy !== 1'b1) begin n_fail++; $display("FAIL short_gap w%0d: got en=%b busy=%b exp 0/1", w, bus6.din_en, bus6.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    pulse_reset();
    test_round_robin();
    test_wrap();
    test_enable();
    test_reset_mid_hold();
    test_short_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
